multdiv_issue_ctrl: RTL and testbench
=====================================

// Module: multdiv_issue_ctrl
// PURPOSE
//  Issue/interlock stage directly upstream of the multdiv unit. Accepts a mult/div op from the execute
//  stage, latches operands + dest reg, pulses ctrl_MULT/ctrl_DIV once, stalls the pipeline until
//  data_resultRDY, then presents one writeback beat. Exceptions are redirected to rstatus with an op code.
// PARAMETERS
//  RSTATUS_REG    30  writeback register used on exception
//  MULT_EXC_CODE  4   value written to rstatus on mult overflow
//  DIV_EXC_CODE   5   value written to rstatus on divide-by-zero
//  TIMEOUT_CYCLES 64  max BUSY cycles before watchdog abort (>=40)
// PORTS
//  clock           in   1   single clock, all state on rising edge
//  reset_n         in   1   synchronous, active-low reset
//  ex_is_mult      in   1   execute-stage instr is mult (level, held while stall=1)
//  ex_is_div       in   1   execute-stage instr is div (level, held while stall=1)
//  ex_opA, ex_opB  in   32  operands from execute stage
//  ex_rd           in   5   destination register
//  ex_flush        in   1   kill the in-flight op (branch/jump squash)
//  data_operandA/B out  32  to multdiv; registered, stable from launch to DONE
//  ctrl_MULT       out  1   to multdiv; one-cycle pulse
//  ctrl_DIV        out  1   to multdiv; one-cycle pulse
//  md_result       in   32  multdiv data_result
//  md_exception    in   1   multdiv data_exception
//  md_resultRDY    in   1   multdiv data_resultRDY
//  stall           out  1   freeze PC/upstream latches
//  wb_valid        out  1   one-cycle writeback strobe
//  wb_rd           out  5   writeback register
//  wb_data         out  32  writeback data
//  wb_timeout      out  1   with wb_valid: op aborted by watchdog
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state=IDLE; all outputs 0; operand/result regs 0; counter 0. Wins over all.
//  FSM IDLE -> START -> BUSY -> DONE -> IDLE.
//   IDLE : req = ex_is_mult|ex_is_div. stall = req (combinational). On req & ~ex_flush: latch
//          opA/opB/rd, is_mult = ex_is_mult (mult wins if both set), go START.
//   START: ctrl_MULT=is_mult / ctrl_DIV=~is_mult for exactly this cycle; stall=1; counter cleared;
//          md_resultRDY ignored this cycle (stale from previous op). -> BUSY.
//   BUSY : stall=1; counter++. md_resultRDY=1: capture md_result/md_exception -> DONE.
//          counter==TIMEOUT_CYCLES-1 without RDY: set timeout flag -> DONE.
//   DONE : stall=0 (pipeline advances at this edge); wb_valid=1 for this single cycle. -> IDLE.
//  Writeback mux (DONE): timeout -> wb_rd=RSTATUS_REG, wb_data=is_mult?MULT_EXC_CODE:DIV_EXC_CODE,
//   wb_timeout=1; exception -> same rd/data, wb_timeout=0; else wb_rd=latched rd, wb_data=result.
//   rd=0 still produces wb_valid (regfile discards r0).
//  Latency: multdiv needing N cycles from ctrl pulse to RDY -> wb_valid N+2 cycles after req seen.
//  ex_flush: IDLE -> no launch; START/BUSY -> IDLE next edge, no wb_valid, stall drops; a late RDY of
//   the killed op is ignored in IDLE; the next op re-pulses ctrl (multdiv restarts on pulse).
//  ex_flush in DONE: ignored (result already committed). ex_* inputs ignored outside IDLE.
//  Back-to-back: new req in the cycle after DONE launches normally; no lost or duplicated pulses.
//  Operands/ctrl pulses never change while multdiv is busy, except on flush.
// STRUCTURE
//  Shared package: state encoding (IDLE/START/BUSY/DONE, 2 bits), RSTATUS_REG, exception code constants.
//  One natural sub-module: md_watchdog (clog2(TIMEOUT_CYCLES)-bit counter, clear/enable, expire flag).
//  Operand/rd/op regs built from dffe_ref instances; FSM in this module.
// TESTING
//  1 mult 7*6, rd=3, multdiv model RDY after 33 cycles -> one ctrl_MULT pulse; stall 35 cycles;
//    wb_valid 1 cycle, wb_rd=3, wb_data=42.
//  2 div 100/0, rd=4, model exception -> wb_rd=30, wb_data=5, wb_timeout=0.
//  3 mult 0x40000000*4 overflow -> wb_rd=30, wb_data=4.
//  4 flush on BUSY cycle 10, then div 9/3 rd=5 next cycle -> no wb for killed op; stale RDY ignored;
//    wb_data=3 rd=5.
//  5 model never raises RDY -> wb_valid with wb_timeout=1, rd=30, code per op, stall drops after 65 cyc.
//  6 reset_n=0 mid-BUSY, then ex_is_mult|ex_is_div both set -> outputs 0 after reset; mult launched
//    (ctrl_MULT only); back-to-back second op starts cycle after DONE.

Source files
------------

// File: rtl/multdiv_issue_ctrl_pkg.sv
// multdiv_issue_ctrl_pkg: shared FSM encoding and exception writeback constants
package multdiv_issue_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_t;
  localparam logic [4:0] RSTATUS_REG = 5'd30;
  localparam logic [31:0] MULT_EXC_CODE = 32'd4;
  localparam logic [31:0] DIV_EXC_CODE = 32'd5;
  function automatic logic [31:0] exc_code(input logic is_mult);
    return is_mult ? MULT_EXC_CODE : DIV_EXC_CODE;
  endfunction
endpackage

// File: rtl/multdiv_issue_ctrl_if.sv
// multdiv_issue_ctrl_if: execute-stage, multdiv and writeback signals of the issue stage
interface multdiv_issue_ctrl_if;
  logic ex_is_mult;
  logic ex_is_div;
  logic [31:0] ex_opA;
  logic [31:0] ex_opB;
  logic [4:0] ex_rd;
  logic ex_flush;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic ctrl_MULT;
  logic ctrl_DIV;
  logic [31:0] md_result;
  logic md_exception;
  logic md_resultRDY;
  logic stall;
  logic wb_valid;
  logic [4:0] wb_rd;
  logic [31:0] wb_data;
  logic wb_timeout;
  modport slave (
    input ex_is_mult, ex_is_div, ex_opA, ex_opB, ex_rd, ex_flush,
    input md_result, md_exception, md_resultRDY,
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output stall, wb_valid, wb_rd, wb_data, wb_timeout
  );
  modport master (
    output ex_is_mult, ex_is_div, ex_opA, ex_opB, ex_rd, ex_flush,
    output md_result, md_exception, md_resultRDY,
    input data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input stall, wb_valid, wb_rd, wb_data, wb_timeout
  );
endinterface

// File: rtl/multdiv_issue_ctrl_dffe.sv
// dffe_ref: enabled register with synchronous active-low clear
module dffe_ref #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock) q <= !reset_n ? '0 : en ? d : q;
endmodule

// File: rtl/multdiv_issue_ctrl_md_watchdog.sv
// md_watchdog: busy-cycle counter that flags expiry on its last allowed cycle
module md_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    expire = en && cnt_q == W'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clock) cnt_q <= !reset_n ? '0 : cnt_d;
endmodule

// File: rtl/multdiv_issue_ctrl.sv
// multdiv_issue_ctrl: launches one mult/div op, stalls the pipe until its result, then emits one writeback beat
module multdiv_issue_ctrl
  import multdiv_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clock,
  input logic reset_n,
  multdiv_issue_ctrl_if.slave io
);
  state_t state_q, state_d;
  logic req, launch, kill, capture, timeout, expire;
  logic is_mult_d, is_mult_q, exc_d, exc_q, to_d, to_q;
  logic [31:0] opa_d, opa_q, opb_d, opb_q, res_d, res_q;
  logic [4:0] rd_d, rd_q;
  always_comb begin
    req = io.ex_is_mult | io.ex_is_div;
    launch = state_q == IDLE && req && !io.ex_flush;
    kill = (state_q == START || state_q == BUSY) && io.ex_flush;
    capture = state_q == BUSY && !io.ex_flush && io.md_resultRDY;
    timeout = state_q == BUSY && !io.ex_flush && !io.md_resultRDY && expire;
    opa_d = io.ex_opA;
    opb_d = io.ex_opB;
    rd_d = io.ex_rd;
    is_mult_d = io.ex_is_mult;
    res_d = io.md_result;
    exc_d = io.md_exception;
    to_d = timeout;
  end
  dffe_ref #(.W(32)) u_opa (.clock, .reset_n, .en(launch), .d(opa_d), .q(opa_q));
  dffe_ref #(.W(32)) u_opb (.clock, .reset_n, .en(launch), .d(opb_d), .q(opb_q));
  dffe_ref #(.W(5)) u_rd (.clock, .reset_n, .en(launch), .d(rd_d), .q(rd_q));
  dffe_ref #(.W(1)) u_is_mult (.clock, .reset_n, .en(launch), .d(is_mult_d), .q(is_mult_q));
  dffe_ref #(.W(32)) u_res (.clock, .reset_n, .en(capture | timeout), .d(res_d), .q(res_q));
  dffe_ref #(.W(1)) u_exc (.clock, .reset_n, .en(capture | timeout), .d(exc_d), .q(exc_q));
  dffe_ref #(.W(1)) u_to (.clock, .reset_n, .en(capture | timeout), .d(to_d), .q(to_q));
  md_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clock,
    .reset_n,
    .clr(state_q == START),
    .en(state_q == BUSY),
    .expire
  );
  always_ff @(posedge clock) state_q <= !reset_n ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = launch ? START : IDLE;
      START: state_d = kill ? IDLE : BUSY;
      BUSY: state_d = kill ? IDLE : (capture || timeout) ? DONE : BUSY;
      default: state_d = IDLE;
    endcase
  end
  // timeout takes precedence over a captured exception when choosing the rstatus redirect
  always_comb begin
    io.stall = state_q == IDLE ? req : state_q != DONE;
    io.ctrl_MULT = state_q == START && is_mult_q;
    io.ctrl_DIV = state_q == START && !is_mult_q;
    io.wb_valid = state_q == DONE;
    io.wb_timeout = state_q == DONE && to_q;
    io.wb_rd = state_q != DONE ? '0 : (to_q || exc_q) ? RSTATUS_REG : rd_q;
    io.wb_data = state_q != DONE ? '0 : (to_q || exc_q) ? exc_code(is_mult_q) : res_q;
    io.data_operandA = opa_q;
    io.data_operandB = opb_q;
  end
endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// tb_multdiv_issue_ctrl: directed vector table driving the issue stage against a behavioural multdiv model
module tb_multdiv_issue_ctrl;
  typedef struct {
    logic mul;
    logic dv;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] rd;
    int lat;
    logic never;
    int pre;
    logic [4:0] e_rd;
    logic [31:0] e_data;
    logic e_to;
    logic e_mul;
    int e_cyc;
  } vec_t;
  logic clk = 0;
  logic reset_n;
  int pass = 0;
  int total = 0;
  int cur_lat = 1;
  logic cur_never = 0;
  logic stale = 0;
  int mcnt = 0;
  logic mrdy = 0;
  logic mexc = 0;
  logic [31:0] mres = 0;
  vec_t vecs[10];
  multdiv_issue_ctrl_if m ();
  multdiv_issue_ctrl #(.TIMEOUT_CYCLES(64)) dut (.clock(clk), .reset_n(reset_n), .io(m.slave));
  always #5 clk = ~clk;
  assign m.md_resultRDY = mrdy | stale;
  assign m.md_exception = stale ? 1'b1 : mexc;
  assign m.md_result = stale ? 32'hDEADBEEF : mres;
  function automatic logic [32:0] md_model(input logic mul, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    if (mul) return {!(p[63:31] == '0 || p[63:31] == '1), p[31:0]};
    return b == 0 ? {1'b1, 32'd0} : {1'b0, 32'($signed(a) / $signed(b))};
  endfunction
  // multdiv restarts on every ctrl pulse and raises RDY for one cycle, cur_lat cycles after the pulse
  always @(negedge clk) begin
    if (m.ctrl_MULT || m.ctrl_DIV) begin
      mcnt <= cur_never ? 0 : cur_lat;
      mrdy <= 1'b0;
      {mexc, mres} <= md_model(m.ctrl_MULT, m.data_operandA, m.data_operandB);
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      mrdy <= mcnt == 1;
    end else begin
      mrdy <= 1'b0;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass++;
  endtask
  task automatic chk_quiet(input string p);
    chk({p, "_stall"}, 32'(m.stall), 0);
    chk({p, "_ctrl_mult"}, 32'(m.ctrl_MULT), 0);
    chk({p, "_ctrl_div"}, 32'(m.ctrl_DIV), 0);
    chk({p, "_wb_valid"}, 32'(m.wb_valid), 0);
    chk({p, "_wb_rd"}, 32'(m.wb_rd), 0);
    chk({p, "_wb_data"}, m.wb_data, 0);
    chk({p, "_wb_timeout"}, 32'(m.wb_timeout), 0);
    chk({p, "_opA"}, m.data_operandA, 0);
    chk({p, "_opB"}, m.data_operandB, 0);
  endtask
  task automatic run_op(input int idx, input vec_t v);
    int cyc, stl, mp, dp, lat;
    logic got;
    logic [31:0] oa, ob, wd;
    logic [4:0] wrd;
    logic wto;
    string t;
    t = $sformatf("v%0d", idx);
    cyc = 0; stl = 0; mp = 0; dp = 0; lat = -1; got = 0;
    oa = 0; ob = 0; wd = 0; wrd = 0; wto = 0;
    cur_lat = v.lat;
    cur_never = v.never;
    m.ex_is_mult = v.mul;
    m.ex_is_div = v.dv;
    m.ex_opA = v.a;
    m.ex_opB = v.b;
    m.ex_rd = v.rd;
    m.ex_flush = 0;
    stale = v.pre == 1;
    while (!got && cyc < 200) begin
      #1;
      if (m.stall) stl++;
      if ((m.ctrl_MULT || m.ctrl_DIV) && mp + dp == 0) begin
        oa = m.data_operandA;
        ob = m.data_operandB;
      end
      if (m.ctrl_MULT) mp++;
      if (m.ctrl_DIV) dp++;
      if (m.wb_valid) begin
        got = 1;
        lat = cyc;
        wrd = m.wb_rd;
        wd = m.wb_data;
        wto = m.wb_timeout;
        m.ex_is_mult = 0;
        m.ex_is_div = 0;
      end
      cyc++;
      @(negedge clk);
      stale = v.pre == 1 && cyc < 2;
    end
    chk({t, "_wb_seen"}, 32'(got), 1);
    chk({t, "_latency"}, lat, v.e_cyc);
    chk({t, "_stall_cycles"}, stl, v.e_cyc);
    chk({t, "_mult_pulses"}, mp, v.e_mul ? 1 : 0);
    chk({t, "_div_pulses"}, dp, v.e_mul ? 0 : 1);
    chk({t, "_opA"}, oa, v.a);
    chk({t, "_opB"}, ob, v.b);
    chk({t, "_wb_rd"}, 32'(wrd), 32'(v.e_rd));
    chk({t, "_wb_data"}, wd, v.e_data);
    chk({t, "_wb_timeout"}, 32'(wto), 32'(v.e_to));
    #1;
    chk({t, "_wb_one_cycle"}, 32'(m.wb_valid), 0);
  endtask
  initial begin
    #300000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic any;
    reset_n = 0;
    m.ex_is_mult = 0; m.ex_is_div = 0; m.ex_opA = 0; m.ex_opB = 0; m.ex_rd = 0; m.ex_flush = 0;
    // mul dv a b rd lat never pre | e_rd e_data e_to e_mul e_cyc
    vecs[0] = '{1'b1, 1'b0, 32'd7, 32'd6, 5'd3, 33, 1'b0, 0, 5'd3, 32'd42, 1'b0, 1'b1, 35};
    vecs[1] = '{1'b0, 1'b1, 32'd100, 32'd0, 5'd4, 33, 1'b0, 0, 5'd30, 32'd5, 1'b0, 1'b0, 35};
    vecs[2] = '{1'b1, 1'b0, 32'h40000000, 32'd4, 5'd6, 33, 1'b0, 0, 5'd30, 32'd4, 1'b0, 1'b1, 35};
    vecs[3] = '{1'b1, 1'b0, 32'd3, 32'd3, 5'd8, 0, 1'b1, 0, 5'd30, 32'd4, 1'b1, 1'b1, 66};
    vecs[4] = '{1'b0, 1'b1, 32'd8, 32'd2, 5'd9, 0, 1'b1, 0, 5'd30, 32'd5, 1'b1, 1'b0, 66};
    vecs[5] = '{1'b0, 1'b1, 32'd9, 32'd3, 5'd5, 4, 1'b0, 1, 5'd5, 32'd3, 1'b0, 1'b0, 6};
    vecs[6] = '{1'b0, 1'b1, 32'd9, 32'd3, 5'd0, 1, 1'b0, 3, 5'd0, 32'd3, 1'b0, 1'b0, 3};
    vecs[7] = '{1'b1, 1'b1, 32'd5, 32'd5, 5'd12, 2, 1'b0, 2, 5'd12, 32'd25, 1'b0, 1'b1, 4};
    vecs[8] = '{1'b0, 1'b1, 32'd1000, 32'd7, 5'd11, 3, 1'b0, 0, 5'd11, 32'd142, 1'b0, 1'b0, 5};
    vecs[9] = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 10, 1'b0, 0, 5'd13, 32'd1, 1'b0, 1'b1, 12};
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("reset");
    reset_n = 1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].pre == 1) begin
        // kill a mult on its tenth busy cycle, then feed a stale RDY while idle and during the next launch
        m.ex_is_mult = 1; m.ex_opA = 7; m.ex_opB = 6; m.ex_rd = 7;
        cur_lat = 33; cur_never = 0; any = 0;
        for (int c = 0; c < 12; c++) begin
          if (c == 11) m.ex_flush = 1;
          #1;
          any = any | m.wb_valid;
          if (c == 11) chk("flush_busy_stall", 32'(m.stall), 1);
          @(negedge clk);
        end
        m.ex_flush = 0; m.ex_is_mult = 0; stale = 1;
        #1;
        chk("flush_stall_drop", 32'(m.stall), 0);
        chk("flush_no_wb", 32'(any | m.wb_valid), 0);
        @(negedge clk);
      end else if (vecs[i].pre == 2) begin
        m.ex_is_div = 1; m.ex_opA = 50; m.ex_opB = 5; m.ex_rd = 14;
        cur_lat = 33; cur_never = 0;
        repeat (6) @(negedge clk);
        chk("pre_reset_busy_stall", 32'(m.stall), 1);
        m.ex_is_div = 0; reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        #1;
        chk_quiet("midbusy_reset");
        @(negedge clk);
      end else if (vecs[i].pre == 3) begin
        m.ex_is_div = 1; m.ex_opA = 77; m.ex_opB = 1; m.ex_rd = 15; m.ex_flush = 1;
        #1;
        chk("idle_flush_req_stall", 32'(m.stall), 1);
        @(negedge clk);
        m.ex_is_div = 0; m.ex_flush = 0;
        #1;
        chk("idle_flush_no_mult", 32'(m.ctrl_MULT), 0);
        chk("idle_flush_no_div", 32'(m.ctrl_DIV), 0);
        chk("idle_flush_stall_low", 32'(m.stall), 0);
        @(negedge clk);
      end
      run_op(i, vecs[i]);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
